// File: rtl/ram_block_mover.sv
// ====================================================================
// ram_block_mover : FILL / COPY / CHECKSUM bus master for the data RAM
// Rev 1.0
// ====================================================================
`default_nettype none

module ram_block_mover #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [6:0]        cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] result,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] WriteData,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam logic [1:0] OP_FILL = 2'd0;
  localparam logic [1:0] OP_COPY = 2'd1;
  localparam logic [1:0] OP_CSUM = 2'd2;
  localparam logic [1:0] OP_RSVD = 2'd3;
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(MEM_DEPTH);

  state_t              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [6:0]          len_q, len_d;
  logic [DATA_W-1:0]   fill_q, fill_d;
  logic [6:0]          idx_q, idx_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  // Range checks are one bit wider than the address so src+len cannot wrap.
  logic [ADDR_W:0]     src_end;
  logic [ADDR_W:0]     dst_end;
  logic                cmd_bad;
  logic [6:0]          idx_nx;
  logic                last;

  assign src_end = {1'b0, cmd_src} + (ADDR_W+1)'(cmd_len);
  assign dst_end = {1'b0, cmd_dst} + (ADDR_W+1)'(cmd_len);
  assign cmd_bad = (cmd_op == OP_RSVD)
                || ((cmd_op != OP_FILL) && (src_end > DEPTH_LIM))
                || ((cmd_op != OP_CSUM) && (dst_end > DEPTH_LIM));
  assign idx_nx  = idx_q + 7'd1;
  assign last    = (idx_nx == len_q);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    src_d       = src_q;
    dst_d       = dst_q;
    len_d       = len_q;
    fill_d      = fill_q;
    idx_d       = idx_q;
    hold_d      = hold_q;
    acc_d       = acc_q;
    result_d    = result_q;
    err_d       = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    address_d   = '0;
    wdata_d     = '0;

    // Outputs are registered, so each branch sets up the access of the next cycle.
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d     = cmd_op;
          src_d    = cmd_src;
          dst_d    = cmd_dst;
          len_d    = cmd_len;
          fill_d   = cmd_data;
          idx_d    = '0;
          acc_d    = '0;
          result_d = '0;
          if (cmd_bad) begin
            state_d = FIN;
            err_d   = 1'b1;
          end else if (cmd_len == 7'd0) begin
            state_d = FIN;
          end else if (cmd_op == OP_FILL) begin
            state_d     = WR;
            mem_write_d = 1'b1;
            address_d   = cmd_dst;
            wdata_d     = cmd_data;
          end else begin
            state_d    = RD;
            mem_read_d = 1'b1;
            address_d  = cmd_src;
          end
        end
      end
      RD: begin
        if (op_q == OP_COPY) begin
          hold_d      = mem_rdata;
          state_d     = WR;
          mem_write_d = 1'b1;
          address_d   = dst_q + ADDR_W'(idx_q);
          wdata_d     = hold_d;
        end else begin
          acc_d = acc_q + mem_rdata;
          if (last) begin
            state_d  = FIN;
            result_d = acc_d;
          end else begin
            idx_d      = idx_nx;
            mem_read_d = 1'b1;
            address_d  = src_q + ADDR_W'(idx_nx);
          end
        end
      end
      WR: begin
        if (last) begin
          state_d = FIN;
        end else begin
          idx_d = idx_nx;
          if (op_q == OP_FILL) begin
            mem_write_d = 1'b1;
            address_d   = dst_q + ADDR_W'(idx_nx);
            wdata_d     = fill_q;
          end else begin
            state_d    = RD;
            mem_read_d = 1'b1;
            address_d  = src_q + ADDR_W'(idx_nx);
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == FIN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      fill_q      <= '0;
      idx_q       <= '0;
      hold_q      <= '0;
      acc_q       <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      result_q    <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      address_q   <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      len_q       <= len_d;
      fill_q      <= fill_d;
      idx_q       <= idx_d;
      hold_q      <= hold_d;
      acc_q       <= acc_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      result_q    <= result_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      address_q   <= address_d;
      wdata_q     <= wdata_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign result    = result_q;
  assign MemRead   = mem_read_q;
  assign MemWrite  = mem_write_q;
  assign Address   = address_q;
  assign WriteData = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_block_mover.sv
// ====================================================================
// tb_ram_block_mover : table-driven scoreboard bench for ram_block_mover
// Rev 1.0
// ====================================================================
`default_nettype none

module tb_ram_block_mover;

  localparam logic [1:0] OP_FILL = 2'd0;
  localparam logic [1:0] OP_COPY = 2'd1;
  localparam logic [1:0] OP_CSUM = 2'd2;
  localparam logic [1:0] OP_RSVD = 2'd3;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_src, cmd_dst, cmd_data;
  logic [6:0] cmd_len;
  logic       busy, done, err;
  logic [7:0] result;
  logic       MemRead, MemWrite;
  logic [7:0] Address, WriteData, mem_rdata;

  always #5 clk = ~clk;

  ram_block_mover #(.ADDR_W(8), .DATA_W(8), .MEM_DEPTH(64)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .busy(busy), .done(done), .err(err), .result(result),
    .MemRead(MemRead), .MemWrite(MemWrite), .Address(Address),
    .WriteData(WriteData), .mem_rdata(mem_rdata)
  );

  // 64-byte RAM: combinational read, write on the clock edge
  logic [7:0] mem [0:63];
  assign mem_rdata = (MemRead && Address < 8'd64) ? mem[Address[5:0]] : 8'h00;
  always @(posedge clk) if (MemWrite && Address < 8'd64) mem[Address[5:0]] <= WriteData;

  int cyc = 0;
  int rd_cnt = 0, wr_cnt = 0, both_cnt = 0, oob_cnt = 0, done_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (MemRead)  rd_cnt <= rd_cnt + 1;
    if (MemWrite) wr_cnt <= wr_cnt + 1;
    if (MemRead && MemWrite) both_cnt <= both_cnt + 1;
    if ((MemRead || MemWrite) && Address >= 8'd64) oob_cnt <= oob_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  typedef struct {
    logic [1:0] op;
    logic [7:0] src;
    logic [7:0] dst;
    logic [6:0] len;
    logic [7:0] data;
    logic       exp_err;
    logic [7:0] exp_res;
    int         exp_lat;
    int         exp_rd;
    int         exp_wr;
  } vec_t;

  typedef struct {
    logic       err;
    logic [7:0] res;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] exp_mem [0:63];
  int         vectors = 0;
  int         miscompares = 0;
  vec_t       tbl[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    end
  endtask

  task automatic check_mem(input string name);
    int bad = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== exp_mem[i]) bad++;
    check(name, bad, 0);
  endtask

  // Reference behaviour: bytes handled one at a time in ascending order
  task automatic model_apply(input vec_t v);
    if (!v.exp_err) begin
      for (int i = 0; i < int'(v.len); i++) begin
        if (v.op == OP_FILL) exp_mem[int'(v.dst) + i] = v.data;
        if (v.op == OP_COPY) exp_mem[int'(v.dst) + i] = exp_mem[int'(v.src) + i];
      end
    end
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < 300);
    if (!done) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic run_cmd(input vec_t v, input bit pulse_busy);
    int   t_acc, rd0, wr0;
    exp_t e;
    @(negedge clk);
    check("ready_idle", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_op = v.op; cmd_src = v.src;
    cmd_dst = v.dst; cmd_len = v.len; cmd_data = v.data;
    sb.push_back('{v.exp_err, v.exp_res, v.exp_lat});
    model_apply(v);
    @(posedge clk); #1;
    t_acc = cyc; rd0 = rd_cnt; wr0 = wr_cnt;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom_range(0, 3)); cmd_src = 8'($urandom);
    cmd_dst = 8'($urandom); cmd_len = 7'($urandom); cmd_data = 8'($urandom);
    if (pulse_busy) begin
      cmd_valid = 1'b1; cmd_op = OP_FILL; cmd_dst = 8'd45; cmd_len = 7'd1; cmd_data = 8'h99;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
    end
    wait_done("cmd");
    e = sb.pop_front();
    check("err", err, e.err);
    check("result", result, e.res);
    check("latency", cyc - t_acc + 1, e.lat);
    @(posedge clk); #1;
    check("reads", rd_cnt - rd0, v.exp_rd);
    check("writes", wr_cnt - wr0, v.exp_wr);
    check("ready_after_fin", {cmd_ready, done}, 2'b10);
    check("result_held", result, e.res);
    check_mem("mem");
  endtask

  initial begin
    int   t0, d0, rd0, wr0;
    exp_t e;

    tbl[0]  = '{OP_FILL, 8'd0,  8'd0,  7'd64, 8'h3C, 1'b0, 8'h00, 65, 0, 64};
    tbl[1]  = '{OP_FILL, 8'd0,  8'd10, 7'd4,  8'hA5, 1'b0, 8'h00, 5,  0, 4};
    tbl[2]  = '{OP_FILL, 8'd0,  8'd0,  7'd1,  8'h01, 1'b0, 8'h00, 2,  0, 1};
    tbl[3]  = '{OP_FILL, 8'd0,  8'd1,  7'd1,  8'h02, 1'b0, 8'h00, 2,  0, 1};
    tbl[4]  = '{OP_FILL, 8'd0,  8'd2,  7'd1,  8'h03, 1'b0, 8'h00, 2,  0, 1};
    tbl[5]  = '{OP_FILL, 8'd0,  8'd3,  7'd1,  8'h04, 1'b0, 8'h00, 2,  0, 1};
    tbl[6]  = '{OP_COPY, 8'd0,  8'd20, 7'd4,  8'h00, 1'b0, 8'h00, 9,  4, 4};
    tbl[7]  = '{OP_FILL, 8'd0,  8'd0,  7'd1,  8'hFF, 1'b0, 8'h00, 2,  0, 1};
    tbl[8]  = '{OP_CSUM, 8'd0,  8'd0,  7'd4,  8'h00, 1'b0, 8'h08, 5,  4, 0};
    tbl[9]  = '{OP_FILL, 8'd0,  8'd60, 7'd5,  8'h55, 1'b1, 8'h00, 1,  0, 0};
    tbl[10] = '{OP_COPY, 8'd0,  8'd63, 7'd2,  8'h00, 1'b1, 8'h00, 1,  0, 0};
    tbl[11] = '{OP_RSVD, 8'd0,  8'd0,  7'd1,  8'h00, 1'b1, 8'h00, 1,  0, 0};
    tbl[12] = '{OP_FILL, 8'd0,  8'd5,  7'd0,  8'h77, 1'b0, 8'h00, 1,  0, 0};
    tbl[13] = '{OP_CSUM, 8'd0,  8'd0,  7'd0,  8'h00, 1'b0, 8'h00, 1,  0, 0};
    tbl[14] = '{OP_FILL, 8'd0,  8'd0,  7'd1,  8'h07, 1'b0, 8'h00, 2,  0, 1};
    tbl[15] = '{OP_FILL, 8'd0,  8'd1,  7'd1,  8'h08, 1'b0, 8'h00, 2,  0, 1};
    tbl[16] = '{OP_FILL, 8'd0,  8'd2,  7'd1,  8'h09, 1'b0, 8'h00, 2,  0, 1};
    tbl[17] = '{OP_FILL, 8'd0,  8'd3,  7'd1,  8'h0A, 1'b0, 8'h00, 2,  0, 1};
    tbl[18] = '{OP_COPY, 8'd0,  8'd1,  7'd3,  8'h00, 1'b0, 8'h00, 7,  3, 3};
    tbl[19] = '{OP_CSUM, 8'd60, 8'd0,  7'd4,  8'h00, 1'b0, 8'hF0, 5,  4, 0};

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0;
    cmd_src = 8'd0; cmd_dst = 8'd0; cmd_len = 7'd0; cmd_data = 8'd0;
    repeat (3) @(negedge clk);
    check("reset_ready", cmd_ready, 1'b1);
    check("reset_outputs", {busy, done, err, result, MemRead, MemWrite, Address, WriteData}, 0);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) run_cmd(tbl[i], 1'b0);

    // explicit spot checks of the first two fills and the overlap result
    check("fill_edge_lo", mem[9], 8'h3C);
    check("fill_edge_hi", mem[14], 8'h3C);
    check("fill_body", {mem[10], mem[13]}, 16'hA5A5);
    check("copy_dst", {mem[20], mem[21], mem[22], mem[23]}, 32'h01020304);
    check("overlap", {mem[0], mem[1], mem[2], mem[3]}, 32'h07070707);

    // Reset during the third cycle of an 8-byte copy: only the first byte lands
    d0 = done_cnt;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_COPY; cmd_src = 8'd0; cmd_dst = 8'd30; cmd_len = 7'd8;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_ready", cmd_ready, 1'b1);
    check("abort_outputs", {busy, done, err, result, MemRead, MemWrite, Address, WriteData}, 0);
    rd0 = rd_cnt; wr0 = wr_cnt;
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    @(posedge clk); #1;
    check("abort_no_access", (rd_cnt - rd0) + (wr_cnt - wr0), 0);
    check("abort_no_done", done_cnt - d0, 0);
    exp_mem[30] = exp_mem[0];
    check_mem("abort_mem");

    // Back-to-back with cmd_valid held: second accept the cycle after FIN
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_FILL; cmd_dst = 8'd40; cmd_len = 7'd2; cmd_data = 8'h11;
    sb.push_back('{1'b0, 8'h00, 3});
    sb.push_back('{1'b0, 8'h00, 2});
    @(posedge clk); #1;
    t0 = cyc;
    cmd_dst = 8'd42; cmd_len = 7'd1; cmd_data = 8'h22;
    wait_done("b2b_first");
    e = sb.pop_front();
    check("b2b_first_lat", cyc - t0 + 1, e.lat);
    check("b2b_first_err", err, e.err);
    @(posedge clk);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("b2b_second_accepted", busy, 1'b1);
    wait_done("b2b_second");
    e = sb.pop_front();
    check("b2b_second_done_cycle", cyc - t0 + 1, 3 + 1 + e.lat);
    check("b2b_second_err", err, e.err);
    exp_mem[40] = 8'h11; exp_mem[41] = 8'h11; exp_mem[42] = 8'h22;
    @(posedge clk); #1;
    check_mem("b2b_mem");

    // A command offered while busy must vanish, not queue
    d0 = done_cnt;
    run_cmd('{OP_FILL, 8'd0, 8'd50, 7'd3, 8'h33, 1'b0, 8'h00, 4, 0, 3}, 1'b1);
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    check("busy_ignored_done", done_cnt - d0, 1);
    check("busy_ignored_mem45", mem[45], exp_mem[45]);

    check("rd_wr_exclusive", both_cnt, 0);
    check("addr_in_range", oob_cnt, 0);
    check("scoreboard_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/ram_block_mover.md
Name: ram_block_mover

Overview:
- Bus master for the 64-byte data RAM port. It drives MemRead, MemWrite, Address and WriteData, and consumes the RAM's combinational read data.
- Accepts one command at a time through a valid/ready handshake. Commands: FILL a range with a constant, COPY a range, or compute an 8-bit CHECKSUM over a range.
- Sits between the control unit (or testbench sequencer) and the RAM. It replaces ad-hoc byte-by-byte accesses for bulk initialisation and moves.

Parameters:
- ADDR_W, 8, width of the RAM address and of the cmd_src/cmd_dst fields.
- DATA_W, 8, width of RAM data, fill value and checksum.
- MEM_DEPTH, 64, number of valid RAM locations. Addresses >= MEM_DEPTH are illegal.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command; high only in IDLE
- cmd_op  in  2  0=FILL, 1=COPY, 2=CHECKSUM, 3=reserved
- cmd_src  in  ADDR_W  source start address (COPY, CHECKSUM)
- cmd_dst  in  ADDR_W  destination start address (COPY, FILL)
- cmd_len  in  7  byte count, 0..64
- cmd_data  in  DATA_W  fill value (FILL only)
- busy  out  1  command in progress (not IDLE)
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; command rejected
- result  out  DATA_W  checksum (CHECKSUM), else 0; held until next accept
- MemRead  out  1  RAM read enable
- MemWrite  out  1  RAM write enable
- Address  out  ADDR_W  RAM address
- WriteData  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, combinational from Address/MemRead

Behaviour:
- Clock and reset: reset is synchronous, active-high; clock is clk. Everything is on the posedge.
- Reset values:
  - state=IDLE, cmd_ready=1.
  - busy, done, err, result, MemRead, MemWrite, Address, WriteData all 0.
  - Internal index, hold and accumulator registers all 0.
  - Reset mid-command aborts immediately. No further RAM accesses occur. No done pulse is produced.
- Output timing:
  - All outputs are driven from flops; no combinational path from cmd_* to outputs.
  - Outside an access cycle: MemRead=MemWrite=0, Address=0, WriteData=0.
- Handshake:
  - A command is accepted on an edge where cmd_valid && cmd_ready. cmd_* fields are captured at that edge; later changes are ignored.
  - cmd_valid while busy is ignored; the command is not queued.
- States: IDLE, RD, WR, FIN.
  - IDLE -> FIN: error, or cmd_len=0.
  - IDLE -> WR: FILL.
  - IDLE -> RD: COPY or CHECKSUM.
  - RD -> WR: COPY.
  - RD -> RD: CHECKSUM with bytes remaining.
  - WR -> RD: COPY with bytes remaining.
  - WR -> WR: FILL with bytes remaining.
  - Last byte -> FIN.
  - FIN -> IDLE.
  - done=1 for exactly the FIN cycle; err and result are valid in that cycle.
- Error check, done at accept:
  - cmd_op=3 is an error.
  - (src + len) > MEM_DEPTH is an error for COPY and CHECKSUM.
  - (dst + len) > MEM_DEPTH is an error for COPY and FILL.
  - Arithmetic is 9-bit, so there is no wrap-around.
  - On error: no RAM access; err=1 in FIN.
  - cmd_len=0 with a legal op is not an error: no access, err=0, result=0.
- Per-byte access, index i = 0..len-1, ascending order only:
  - FILL: one WR cycle per byte. Address=dst+i, WriteData=cmd_data, MemWrite=1.
  - COPY: RD cycle (Address=src+i, MemRead=1), then WR cycle (Address=dst+i, MemWrite=1, WriteData=hold).
    - mem_rdata is sampled into hold at the end of the RD cycle.
    - Overlapping ranges are processed in ascending order. With dst > src, already-written bytes are re-read, giving a propagation pattern. This is defined behaviour.
  - CHECKSUM: one RD cycle per byte. acc = (acc + mem_rdata) mod 256, sampled at the end of the RD cycle. result=acc at FIN.
- Latency (accept edge = cycle T):
  - FILL: accesses in T+1..T+N, done at T+N+1.
  - COPY: 2N access cycles, done at T+2N+1.
  - CHECKSUM: done at T+N+1.
  - Error or len=0: done at T+1.
- Throughput:
  - cmd_ready returns high the cycle after FIN.
  - Minimum spacing between accepts is 2 cycles (len=0 or error).
- MemRead and MemWrite are never asserted in the same cycle.

Test Plan:
- FILL dst=10 len=4 data=0xA5 -> MemWrite high for 4 consecutive cycles at addresses 10..13. done at T+5, err=0. RAM[10..13]=0xA5; RAM[9] and RAM[14] unchanged.
- Preload RAM[0..3]=1,2,3,4, then COPY src=0 dst=20 len=4 -> alternating RD/WR for 8 cycles. done at T+9. RAM[20..23]=1,2,3,4.
- CHECKSUM src=0 len=4 over {0xFF,0x02,0x03,0x04} -> result=0x08 (mod-256 wrap). done at T+5.
- Rejected commands, each -> done at T+1 with err=1 and zero RAM strobes:
  - FILL dst=60 len=5.
  - COPY src=0 dst=63 len=2.
  - cmd_op=3.
- Boundary and overlap:
  - FILL dst=0 len=64 -> full memory written, err=0.
  - len=0 -> done at T+1, err=0, no strobes.
  - Overlap COPY src=0 dst=1 len=3 with RAM[0..3]=7,8,9,10 -> RAM[0..3]=7,7,7,7.
- Reset, back-to-back and ignored commands:
  - Assert reset on the 3rd cycle of COPY len=8 -> next cycle all outputs 0, cmd_ready=1, no done pulse.
  - Then two back-to-back commands with cmd_valid held high -> second command accepted the cycle after the first FIN.
  - cmd_valid pulsed while busy is ignored.
